// File: rtl/fetch_pkg.sv
// Shared types for the fetch-address generator and its optional branch target buffer.
package fetch_pkg;

  // Widest supported address; BTB entry fields are sized to this and zero-extended.
  localparam int unsigned XLEN_MAX = 64;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_TARGET = 2'b01,
    PC_ALU    = 2'b10
  } pc_src_e;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic                valid;
    logic [XLEN_MAX-1:0] tag;
    logic [XLEN_MAX-1:0] target;
  } btb_entry_t;

  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_btb.sv
// Direct-mapped branch target buffer: combinational lookup, write on the clock edge.
module fetch_btb
  import fetch_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ENTRIES = 8
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic [XLEN-1:0] i_lookup_pc,
  input  logic            i_upd,
  input  logic [XLEN-1:0] i_upd_pc,
  input  logic [XLEN-1:0] i_upd_target,
  output logic            o_hit_c,
  output logic [XLEN-1:0] o_target_c
);

  localparam int unsigned IW = $clog2(ENTRIES);

  btb_entry_t r_mem [ENTRIES];

  logic [IW-1:0] w_rd_idx;
  logic [IW-1:0] w_wr_idx;
  btb_entry_t    w_rd_entry;
  btb_entry_t    w_wr_entry;

  // Lookup reads the stored array, so a same-cycle update is seen only from the next cycle.
  always_comb begin
    w_rd_idx          = i_lookup_pc[IW+1:2];
    w_wr_idx          = i_upd_pc[IW+1:2];
    w_rd_entry        = r_mem[w_rd_idx];
    w_wr_entry.valid  = 1'b1;
    w_wr_entry.tag    = XLEN_MAX'(i_upd_pc[XLEN-1:IW+2]);
    w_wr_entry.target = XLEN_MAX'(i_upd_target);
    o_hit_c           = w_rd_entry.valid &&
                        (w_rd_entry.tag == XLEN_MAX'(i_lookup_pc[XLEN-1:IW+2]));
    o_target_c        = w_rd_entry.target[XLEN-1:0];
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < int'(ENTRIES); i++) r_mem[i] <= '0;
    end else if (i_upd) begin
      r_mem[w_wr_idx] <= w_wr_entry;
    end
  end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator with valid/ready handshake, pending-redirect buffer and misaligned trap.
// Define FETCH_BTB_EN to add the branch target buffer predictor.
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int unsigned     BTB_ENTRIES  = 8
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic            FetchReady,
  input  logic [1:0]      PCSrc,
  input  logic [XLEN-1:0] PCTarget,
  input  logic [XLEN-1:0] ALUResult,
  input  logic            BTBUpdate,
  input  logic [XLEN-1:0] BTBUpdatePC,
  input  logic [XLEN-1:0] BTBUpdateTarget,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PCPlus4,
  output logic            PCValid,
  output logic            PredTaken,
  output logic            MisalignedTrap,
  output logic [XLEN-1:0] MisalignedAddr
);

  fetch_state_e    r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pc_plus4;
  logic            r_pc_valid;
  logic            r_pend_valid;
  logic [XLEN-1:0] r_pend_target;
  logic            r_trap;
  logic [XLEN-1:0] r_maddr;

  logic            w_btb_hit;
  logic [XLEN-1:0] w_btb_target;
  logic            w_accept;
  logic            w_in_redirect;
  logic [XLEN-1:0] w_in_target;
  logic            w_eff_valid;
  logic [XLEN-1:0] w_eff_target;
  logic            w_take_trap;
  logic [XLEN-1:0] w_next_pc;

`ifdef FETCH_BTB_EN
  fetch_btb #(
    .XLEN    (XLEN),
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .CLK          (CLK),
    .Reset        (Reset),
    .i_lookup_pc  (r_pc),
    .i_upd        (BTBUpdate),
    .i_upd_pc     (BTBUpdatePC),
    .i_upd_target (BTBUpdateTarget),
    .o_hit_c      (w_btb_hit),
    .o_target_c   (w_btb_target)
  );
`else
  assign w_btb_hit    = 1'b0;
  assign w_btb_target = '0;
`endif

  // Redirect selection and next-PC priority: redirect, then prediction, then sequential.
  always_comb begin
    w_in_redirect = 1'b0;
    w_in_target   = '0;
    w_next_pc     = r_pc;
    w_accept      = (r_state == RUN) && FetchReady;
    case (pc_src_e'(PCSrc))
      PC_TARGET: begin
        w_in_redirect = (r_state == RUN);
        w_in_target   = PCTarget;
      end
      PC_ALU: begin
        w_in_redirect = (r_state == RUN);
        w_in_target   = {ALUResult[XLEN-1:1], 1'b0};
      end
      default: ;
    endcase
    w_eff_valid  = w_in_redirect || r_pend_valid;
    w_eff_target = w_in_redirect ? w_in_target : r_pend_target;
    w_take_trap  = w_accept && w_eff_valid && is_misaligned(w_eff_target[1:0]);
    if (w_accept) begin
      if (w_eff_valid)    w_next_pc = w_take_trap ? TRAP_VECTOR : w_eff_target;
      else if (w_btb_hit) w_next_pc = w_btb_target;
      else                w_next_pc = r_pc_plus4;
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state       <= BOOT;
      r_pc          <= RESET_VECTOR;
      r_pc_plus4    <= RESET_VECTOR + XLEN'(4);
      r_pc_valid    <= 1'b0;
      r_pend_valid  <= 1'b0;
      r_pend_target <= '0;
      r_trap        <= 1'b0;
      r_maddr       <= '0;
    end else begin
      case (r_state)
        BOOT: begin
          r_state    <= RUN;
          r_pc_valid <= 1'b1;
          r_trap     <= 1'b0;
        end
        RUN: begin
          r_pc       <= w_next_pc;
          r_pc_plus4 <= w_next_pc + XLEN'(4);
          r_trap     <= w_take_trap;
          if (w_take_trap) r_maddr <= w_eff_target;
          // Stalled redirects park here; the newest one overwrites any older one.
          if (w_accept) begin
            r_pend_valid <= 1'b0;
          end else if (w_in_redirect) begin
            r_pend_valid  <= 1'b1;
            r_pend_target <= w_in_target;
          end
        end
        default: r_state <= BOOT;
      endcase
    end
  end

  assign PC             = r_pc;
  assign PCPlus4        = r_pc_plus4;
  assign PCValid        = r_pc_valid;
  assign PredTaken      = w_btb_hit;
  assign MisalignedTrap = r_trap;
  assign MisalignedAddr = r_maddr;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Self-checking bench for fetch_pc_gen: directed vector table, corner sequences, random vs. model.
module tb_fetch_pc_gen;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] RV   = 32'h0;
  localparam logic [31:0] TV   = 32'h100;
  localparam int unsigned NBTB = 8;
  localparam int unsigned IW   = 3;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        FetchReady;
  logic [1:0]  PCSrc;
  logic [31:0] PCTarget, ALUResult;
  logic        BTBUpdate;
  logic [31:0] BTBUpdatePC, BTBUpdateTarget;
  logic [31:0] PC, PCPlus4, MisalignedAddr;
  logic        PCValid, PredTaken, MisalignedTrap;

  fetch_pc_gen #(
    .XLEN(XLEN), .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .BTB_ENTRIES(NBTB)
  ) dut (
    .CLK(CLK), .Reset(Reset), .FetchReady(FetchReady), .PCSrc(PCSrc),
    .PCTarget(PCTarget), .ALUResult(ALUResult), .BTBUpdate(BTBUpdate),
    .BTBUpdatePC(BTBUpdatePC), .BTBUpdateTarget(BTBUpdateTarget),
    .PC(PC), .PCPlus4(PCPlus4), .PCValid(PCValid), .PredTaken(PredTaken),
    .MisalignedTrap(MisalignedTrap), .MisalignedAddr(MisalignedAddr)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural state from the rules, BTB as associative arrays.
  bit          m_boot, m_pend_v, m_trap;
  logic [31:0] m_pc, m_pend_t, m_maddr;
  logic [31:0] m_btb_tag [int];
  logic [31:0] m_btb_tgt [int];

  function automatic int btb_idx(input logic [31:0] a);
    return int'((a >> 2) % NBTB);
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
`ifdef FETCH_BTB_EN
    int i = btb_idx(a);
    return m_btb_tag.exists(i) && (m_btb_tag[i] == (a >> (IW + 2)));
`else
    return a === 32'hx;
`endif
  endfunction

  task automatic model_reset();
    m_boot = 1; m_pend_v = 0; m_trap = 0;
    m_pc = RV; m_pend_t = 0; m_maddr = 0;
    m_btb_tag.delete(); m_btb_tgt.delete();
  endtask

  task automatic model_edge();
    bit          red, hit;
    logic [31:0] t, e, ptgt;
    hit  = m_hit(m_pc);
    ptgt = hit ? m_btb_tgt[btb_idx(m_pc)] : 32'h0;
    m_trap = 0;
    if (m_boot) begin
      m_boot = 0;
    end else begin
      red = (PCSrc == 2'd1) || (PCSrc == 2'd2);
      t   = (PCSrc == 2'd1) ? PCTarget : (ALUResult & ~32'h1);
      if (FetchReady) begin
        if (red || m_pend_v) begin
          e = red ? t : m_pend_t;
          m_pend_v = 0;
          if (e % 4 != 0) begin m_pc = TV; m_maddr = e; m_trap = 1; end
          else m_pc = e;
        end else if (hit) begin
          m_pc = ptgt;
        end else begin
          m_pc = m_pc + 32'd4;
        end
      end else if (red) begin
        m_pend_v = 1; m_pend_t = t;
      end
    end
`ifdef FETCH_BTB_EN
    if (BTBUpdate) begin
      m_btb_tag[btb_idx(BTBUpdatePC)] = BTBUpdatePC >> (IW + 2);
      m_btb_tgt[btb_idx(BTBUpdatePC)] = BTBUpdateTarget;
    end
`endif
  endtask

  task automatic check_all(input string tag);
    check({tag, ".PC"},      PC,                     m_pc);
    check({tag, ".PCPlus4"}, PCPlus4,                m_pc + 32'd4);
    check({tag, ".PCValid"}, 32'(PCValid),           32'(!m_boot));
    check({tag, ".Pred"},    32'(PredTaken),         32'(m_hit(m_pc)));
    check({tag, ".Trap"},    32'(MisalignedTrap),    32'(m_trap));
    check({tag, ".MAddr"},   MisalignedAddr,         m_maddr);
  endtask

  // Drive inputs at the falling edge, let one rising edge pass, compare at the next falling edge.
  task automatic cycle(input bit fr, input logic [1:0] src, input logic [31:0] tgt,
                       input logic [31:0] alu, input bit upd = 0,
                       input logic [31:0] upd_pc = 0, input logic [31:0] upd_t = 0);
    FetchReady = fr; PCSrc = src; PCTarget = tgt; ALUResult = alu;
    BTBUpdate = upd; BTBUpdatePC = upd_pc; BTBUpdateTarget = upd_t;
    @(posedge CLK);
    if (!Reset) model_edge();
    @(negedge CLK);
    check_all("cyc");
  endtask

  task automatic async_reset();
    Reset = 1'b1;
    #1;
    model_reset();
    check_all("rst");
    @(negedge CLK);
    Reset = 1'b0;
  endtask

  typedef struct {
    bit          fr;
    logic [1:0]  src;
    logic [31:0] tgt;
    logic [31:0] alu;
    logic [31:0] e_pc;
    bit          e_valid;
    bit          e_trap;
    logic [31:0] e_maddr;
  } vec_t;

  vec_t vt[13];

  initial begin
    vt[0]  = '{1, 2'b00, 32'h0,  32'h0,  32'h0,   1, 0, 32'h0};
    vt[1]  = '{1, 2'b00, 32'h0,  32'h0,  32'h4,   1, 0, 32'h0};
    vt[2]  = '{1, 2'b00, 32'h0,  32'h0,  32'h8,   1, 0, 32'h0};
    vt[3]  = '{0, 2'b00, 32'h0,  32'h0,  32'h8,   1, 0, 32'h0};
    vt[4]  = '{0, 2'b00, 32'h0,  32'h0,  32'h8,   1, 0, 32'h0};
    vt[5]  = '{0, 2'b00, 32'h0,  32'h0,  32'h8,   1, 0, 32'h0};
    vt[6]  = '{1, 2'b00, 32'h0,  32'h0,  32'hC,   1, 0, 32'h0};
    vt[7]  = '{1, 2'b00, 32'h0,  32'h0,  32'h10,  1, 0, 32'h0};
    vt[8]  = '{0, 2'b01, 32'h40, 32'h0,  32'h10,  1, 0, 32'h0};
    vt[9]  = '{0, 2'b10, 32'h0,  32'h81, 32'h10,  1, 0, 32'h0};
    vt[10] = '{1, 2'b00, 32'h0,  32'h0,  32'h80,  1, 0, 32'h0};
    vt[11] = '{1, 2'b01, 32'h42, 32'h0,  32'h100, 1, 1, 32'h42};
    vt[12] = '{1, 2'b00, 32'h0,  32'h0,  32'h104, 1, 0, 32'h42};

    FetchReady = 1; PCSrc = 0; PCTarget = 0; ALUResult = 0;
    BTBUpdate = 0; BTBUpdatePC = 0; BTBUpdateTarget = 0;
    Reset = 1'b1;
    model_reset();
    repeat (2) @(negedge CLK);
    check_all("reset");
    check("reset.PCValid", 32'(PCValid), 32'd0);
    check("reset.PCPlus4", PCPlus4, RV + 32'd4);
    Reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      cycle(vt[i].fr, vt[i].src, vt[i].tgt, vt[i].alu);
      check($sformatf("vec%0d.PC", i),    PC,                  vt[i].e_pc);
      check($sformatf("vec%0d.Valid", i), 32'(PCValid),        32'(vt[i].e_valid));
      check($sformatf("vec%0d.Trap", i),  32'(MisalignedTrap), 32'(vt[i].e_trap));
      check($sformatf("vec%0d.MAddr", i), MisalignedAddr,      vt[i].e_maddr);
    end

    // Address wrap at the top of the space.
    cycle(1, 2'b01, 32'hFFFF_FFFC, 0);
    check("wrap.PC", PC, 32'hFFFF_FFFC);
    check("wrap.PCPlus4", PCPlus4, 32'h0);
    cycle(1, 2'b00, 0, 0);
    check("wrap.next", PC, 32'h0);

    // Reset during a stall with a pending redirect: the redirect must be dropped.
    cycle(0, 2'b01, 32'h200, 0);
    async_reset();
    check("midrst.PC", PC, RV);
    cycle(1, 2'b00, 0, 0);
    cycle(1, 2'b00, 0, 0);
    check("midrst.nostale", PC, 32'h4);

`ifdef FETCH_BTB_EN
    async_reset();
    cycle(1, 2'b00, 0, 0, 1, 32'h20, 32'h60);
    repeat (8) cycle(1, 2'b00, 0, 0);
    check("btb.at20", PC, 32'h20);
    check("btb.pred", 32'(PredTaken), 32'd1);
    cycle(1, 2'b00, 0, 0);
    check("btb.taken", PC, 32'h60);
    async_reset();
    cycle(1, 2'b00, 0, 0, 1, 32'h20, 32'h60);
    repeat (8) cycle(1, 2'b00, 0, 0);
    check("btb.pred2", 32'(PredTaken), 32'd1);
    cycle(1, 2'b01, 32'h30, 0);
    check("btb.redir", PC, 32'h30);
`endif

    // Random traffic against the model, with occasional asynchronous resets.
    for (int k = 0; k < 3000; k++) begin
      logic [31:0] tgt, alu, upc;
      if ($urandom_range(0, 299) == 0) async_reset();
      tgt = $urandom & 32'h0000_00FC;
      if ($urandom_range(0, 7) == 0) tgt = tgt | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 49) == 0) tgt = 32'hFFFF_FFF8;
      alu = $urandom & 32'h0000_00FF;
      upc = ($urandom & 32'h0000_00FF) & ~32'h3;
      cycle(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), tgt, alu,
            ($urandom_range(0, 5) == 0), upc, ($urandom & 32'h0000_00FF) & ~32'h3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_pc_gen.md
# fetch_pc_gen

Parametrised fetch-address generator for the pipelined core; it replaces the single-cycle program counter. It holds the fetch PC and presents it to instruction memory with a valid/ready handshake. It applies redirects from execute (branch, JAL, JALR) with a pending-redirect buffer while fetch is back-pressured, and traps misaligned targets. An optional branch target buffer (BTB) predicts taken branches.

## Interface
- XLEN, 32, address width (≥16)
- RESET_VECTOR, 0, PC loaded on reset
- TRAP_VECTOR, 32'h0000_0100, PC loaded on misaligned redirect
- BTB_ENTRIES, 8, BTB depth, power of 2, ≥2 (used only with FETCH_BTB_EN)
- CLK  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-high
- FetchReady  in  1  instruction memory accepts PC this cycle
- PCSrc  in  2  redirect select: 00 none, 01 PCTarget, 10 ALUResult (JALR), 11 reserved (treated as 00)
- PCTarget  in  XLEN  branch/JAL target
- ALUResult  in  XLEN  JALR target; bit 0 cleared before use
- BTBUpdate  in  1  write BTB entry (resolved taken branch)
- BTBUpdatePC  in  XLEN  branch PC to write
- BTBUpdateTarget  in  XLEN  branch target to write
- PC  out  XLEN  current fetch address
- PCPlus4  out  XLEN  PC + 4, mod 2^XLEN
- PCValid  out  1  fetch request valid
- PredTaken  out  1  BTB hit on current PC
- MisalignedTrap  out  1  one-cycle pulse when a misaligned redirect is taken
- MisalignedAddr  out  XLEN  last faulting target, sticky

## Operation
- States: BOOT, RUN.
  - BOOT: PCValid=0 and PC=RESET_VECTOR for one cycle after Reset deasserts; then RUN.
  - RUN: PCValid=1 always.
- Handshake: a fetch is accepted at a rising edge when PCValid && FetchReady. PC changes only at an accepted edge or at a redirect edge. It is stable while PCValid && !FetchReady.
- Next-PC priority at an accepted edge:
  1. effective redirect (incoming, else pending)
  2. BTB prediction
  3. PCPlus4
- Redirect (PCSrc 01/10) in RUN:
  - If FetchReady=1, PC takes the target at that edge.
  - If FetchReady=0, the target is latched into the pending register (PendValid=1). PC stays unchanged, preserving handshake stability, and the pending target is applied at the next accepted edge.
  - A second redirect while one is pending overwrites it; the newest wins.
  - PendValid clears when applied.
- Misaligned target: effective target[1:0] ≠ 00, checked after the JALR bit-0 clear. Action:
  - PC ← TRAP_VECTOR.
  - MisalignedAddr ← target.
  - MisalignedTrap=1 for the cycle after the edge.
  - A misaligned target is still subject to the pending rules; the check runs when the target is applied.
- Redirects in BOOT are ignored.
- Addition wraps modulo 2^XLEN; no overflow flag.

## Timing
- Reset values: PC=RESET_VECTOR, PCPlus4=RESET_VECTOR+4, PCValid=0, PredTaken=0, MisalignedTrap=0, MisalignedAddr=0, PendValid=0, state=BOOT, all BTB valid bits 0.
- First accepted fetch is at the second rising edge after Reset release, provided FetchReady=1.
- Redirect-to-PC latency: 1 edge when unstalled, otherwise at the first accepted edge.
- PredTaken is combinational from PC and BTB contents.
- A BTB write is visible to lookups from the cycle after the write edge.
- Reset asserted mid-operation: all state returns to reset values immediately, pending redirect discarded.

## Configuration
- FETCH_BTB_EN defined:
  - Direct-mapped BTB, BTB_ENTRIES entries.
  - Index = PC[log2(BTB_ENTRIES)+1:2]; tag = remaining upper bits; one valid bit per entry.
  - Hit → PredTaken=1 and next PC = stored target.
  - BTBUpdate writes index/tag/target and sets valid; a write to an occupied index replaces the entry.
  - Lookup and update to the same index in the same cycle: lookup sees the old entry.
- Not defined:
  - No BTB storage; PredTaken tied 0.
  - BTBUpdate* inputs are ignored.
  - Next PC is redirect or PCPlus4 only.

## Structure
- Shared package fetch_pkg:
  - pc_src_e enum: PC_SEQ=2'b00, PC_TARGET=2'b01, PC_ALU=2'b10.
  - fetch_state_e enum: BOOT, RUN.
  - btb_entry_t struct: valid, tag, target.
- One sub-module, fetch_btb (lookup + update array). It is instantiated only under FETCH_BTB_EN.

## Test plan
- Reset release, FetchReady=1 → PCValid 0 for one cycle, then PC sequence 0x0, 0x4, 0x8.
- FetchReady=0 for 3 cycles at PC=0x8 → PC held at 0x8; advances to 0xC when ready returns.
- At PC=0x10, FetchReady=0, PCSrc=01 with PCTarget=0x40; then PCSrc=10 with ALUResult=0x81 → PC stays 0x10; on ready, PC=0x80 (newest wins, bit 0 cleared).
- PCSrc=01 with PCTarget=0x42 → PC=0x100, MisalignedTrap pulses one cycle, MisalignedAddr=0x42.
- FETCH_BTB_EN: BTBUpdate PC=0x20, target=0x60, then fetch reaches 0x20 → PredTaken=1, next PC=0x60. Redirect at the same edge to 0x30 → PC=0x30.
- Reset asserted mid-stall with a pending redirect → PC=RESET_VECTOR; after release no stale redirect is applied.
